shapool_job_ctrl: RTL and testbench
===================================

Name: shapool_job_ctrl

Overview:
Job sequencer for the hashing pool in the HX8K build; runs on the PLL-derived global clock inside top.
- Holds the pool in reset until the PLL is stably locked.
- On each loaded job, steps the pool through nonce rounds and detects success.
- Arbitrates among cores reporting success and latches the winner.
- Drives the READY flag and the status LED.

Parameters:
POOL_SIZE, 2, number of hashing cores in the pool
POOL_SIZE_LOG2, 1, width of the winner index
NONCE_WIDTH, 32, width of the round nonce counter
ROUND_CYCLES, 66, clock cycles per hash round (>=2)
STARTUP_CYCLES, 16, consecutive locked cycles required before leaving WAIT_LOCK (>=1)
LED_DIV, 22, heartbeat divider exponent for the LED

Ports:
clk_in  input  1  global clock (PLL output)
reset_in  input  1  synchronous, active-high reset
pll_locked_in  input  1  PLL LOCK
job_valid_in  input  1  one-cycle pulse: new job fully loaded
job_abort_in  input  1  one-cycle pulse: abandon current job
nonce_end_in  input  NONCE_WIDTH  last round nonce to try, inclusive
core_success_in  input  POOL_SIZE  per-core success, valid in CHECK
core_reset_out  output  1  pool reset
core_start_out  output  1  one-cycle round-start strobe
nonce_out  output  NONCE_WIDTH  current round nonce
winner_idx_out  output  POOL_SIZE_LOG2  latched winning core index
winner_nonce_out  output  NONCE_WIDTH  latched winning round nonce
ready_out  output  1  high while in FOUND
exhausted_out  output  1  high while in EXHAUSTED
busy_out  output  1  high in START, RUN and CHECK
status_led_out  output  1  active-high LED drive

Behaviour:
Reset values:
- State = WAIT_LOCK; core_reset_out = 1.
- All counters, nonce_out, winner_idx_out, winner_nonce_out = 0.
- core_start_out, ready_out, exhausted_out, busy_out, status_led_out = 0.
- Reset has priority over every other input.

Global precedence: reset > pll_locked_in low > job_abort_in > job_valid_in. pll_locked_in low in any state -> WAIT_LOCK next cycle, lock counter cleared.

States:
- WAIT_LOCK:
  - core_reset_out = 1.
  - Lock counter increments each cycle pll_locked_in = 1 and clears on any 0.
  - When the counter reaches STARTUP_CYCLES -> IDLE.
  - Job inputs ignored.
- IDLE:
  - core_reset_out = 0.
  - job_valid_in -> nonce_out <= 0, then START.
- START (1 cycle):
  - core_start_out = 1.
  - Round counter <= ROUND_CYCLES-2, then RUN.
- RUN:
  - Round counter decrements each cycle.
  - When it is 0 -> CHECK.
  - The START strobe to the first CHECK cycle is exactly ROUND_CYCLES cycles.
- CHECK (1 cycle): sample core_success_in.
  - Any bit set -> FOUND. winner_idx_out <= lowest set index (fixed priority, bit 0 highest); winner_nonce_out <= nonce_out.
  - Else if nonce_out == nonce_end_in -> EXHAUSTED. nonce_out holds and never wraps; nonce_end_in = all-ones terminates correctly.
  - Else nonce_out <= nonce_out+1, then START.
- FOUND:
  - ready_out = 1; winner outputs stable.
  - job_valid_in -> nonce_out <= 0, START.
  - job_abort_in -> IDLE.
- EXHAUSTED:
  - exhausted_out = 1.
  - job_valid_in -> nonce_out <= 0, START.
  - job_abort_in -> IDLE.

Busy-state events (START, RUN, CHECK):
- job_abort_in -> IDLE, with core_reset_out = 1 for exactly one cycle (the first IDLE cycle).
- job_valid_in -> supersedes the current job: nonce_out <= 0, START next cycle, no core_reset pulse.
- Both asserted together -> abort wins.

Winner registers:
- Change only on a CHECK -> FOUND transition.
- Cleared to 0 on job_valid_in acceptance.

status_led_out:
- Toggles every 2^LED_DIV cycles while busy_out = 1, from a free-running counter cleared on entry to START from a non-busy state.
- Solid 1 in FOUND.
- 0 in all other states.

All outputs are registered, except busy_out and ready_out, which decode directly from the state register.

Test Plan:
1. Reset, pll_locked_in = 1 from cycle 0, STARTUP_CYCLES=16 -> core_reset_out falls exactly 16 cycles after reset release; lock glitch at cycle 10 restarts the count.
2. ROUND_CYCLES=66, job_valid_in pulse, core_success_in = 2'b00 with nonce_end_in = 2 -> three core_start_out pulses spaced 67 cycles apart, with nonce_out 0, 1, 2; then exhausted_out = 1 and nonce_out stays 2.
3. Success 2'b11 in the second CHECK -> winner_idx_out = 0, winner_nonce_out = 1, ready_out = 1 and status_led_out = 1 from the next cycle; both hold until job_abort_in.
4. job_abort_in during RUN -> next cycle IDLE, core_reset_out high for one cycle, core_start_out never asserts; abort and valid together -> IDLE.
5. job_valid_in mid-RUN at nonce 5 -> next cycle START with nonce_out = 0, no core_reset pulse.
6. nonce_end_in = 32'hFFFFFFFF, preload nonce_out near the end via a forced counter -> reaches EXHAUSTED at 32'hFFFFFFFF with no wrap to 0; pll_locked_in drop in FOUND -> WAIT_LOCK, ready_out = 0.

Source files
------------

// File: rtl/shapool_job_ctrl.sv
// Job sequencer for the hashing pool: gates the pool on PLL lock, steps nonce
// rounds for each loaded job, arbitrates core success and drives READY/LED.
module shapool_job_ctrl #(
  parameter int POOL_SIZE      = 2,
  parameter int POOL_SIZE_LOG2 = 1,
  parameter int NONCE_WIDTH    = 32,
  parameter int ROUND_CYCLES   = 66,
  parameter int STARTUP_CYCLES = 16,
  parameter int LED_DIV        = 22
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic                      pll_locked_in,
  input  logic                      job_valid_in,
  input  logic                      job_abort_in,
  input  logic [NONCE_WIDTH-1:0]    nonce_end_in,
  input  logic [POOL_SIZE-1:0]      core_success_in,
  output logic                      core_reset_out,
  output logic                      core_start_out,
  output logic [NONCE_WIDTH-1:0]    nonce_out,
  output logic [POOL_SIZE_LOG2-1:0] winner_idx_out,
  output logic [NONCE_WIDTH-1:0]    winner_nonce_out,
  output logic                      ready_out,
  output logic                      exhausted_out,
  output logic                      busy_out,
  output logic                      status_led_out
);

  localparam logic [2:0] S_WAIT_LOCK = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_CHECK     = 3'd4;
  localparam logic [2:0] S_FOUND     = 3'd5;
  localparam logic [2:0] S_EXHAUSTED = 3'd6;

  localparam int LW = $clog2(STARTUP_CYCLES + 1);
  localparam int RW = (ROUND_CYCLES > 2) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [LW-1:0] LOCK_LAST  = LW'(STARTUP_CYCLES - 1);
  localparam logic [RW-1:0] ROUND_LOAD = RW'(ROUND_CYCLES - 2);

  logic [2:0]                state, state_nxt;
  logic [LW-1:0]             lock_cnt, lock_cnt_nxt;
  logic [RW-1:0]             round_cnt, round_cnt_nxt;
  logic [NONCE_WIDTH-1:0]    nonce_nxt, win_nonce_nxt;
  logic [POOL_SIZE_LOG2-1:0] win_idx_nxt, prio_idx;
  logic [LED_DIV:0]          led_cnt, led_cnt_nxt;
  logic                      busy_nxt, pool_rst_pulse, any_success;

  assign busy_out  = (state == S_START) || (state == S_RUN) || (state == S_CHECK);
  assign ready_out = (state == S_FOUND);
  assign busy_nxt  = (state_nxt == S_START) || (state_nxt == S_RUN) || (state_nxt == S_CHECK);

  // Fixed priority: lowest set index wins
  always_comb begin
    prio_idx = '0;
    for (int i = POOL_SIZE - 1; i >= 0; i--)
      if (core_success_in[i]) prio_idx = POOL_SIZE_LOG2'(i);
  end
  assign any_success = |core_success_in;

  always_comb begin
    state_nxt      = state;
    lock_cnt_nxt   = lock_cnt;
    round_cnt_nxt  = round_cnt;
    nonce_nxt      = nonce_out;
    win_idx_nxt    = winner_idx_out;
    win_nonce_nxt  = winner_nonce_out;
    pool_rst_pulse = 1'b0;
    if (!pll_locked_in) begin
      state_nxt    = S_WAIT_LOCK;
      lock_cnt_nxt = '0;
    end else if (state == S_WAIT_LOCK) begin
      lock_cnt_nxt = lock_cnt + 1'b1;
      if (lock_cnt == LOCK_LAST) state_nxt = S_IDLE;
    end else if (job_abort_in) begin
      // Only an abort of a running job needs the pool flushed
      state_nxt      = S_IDLE;
      pool_rst_pulse = busy_out;
    end else if (job_valid_in) begin
      state_nxt     = S_START;
      nonce_nxt     = '0;
      win_idx_nxt   = '0;
      win_nonce_nxt = '0;
    end else begin
      case (state)
        S_START: begin
          round_cnt_nxt = ROUND_LOAD;
          state_nxt     = S_RUN;
        end
        S_RUN: begin
          if (round_cnt == '0) state_nxt = S_CHECK;
          else round_cnt_nxt = round_cnt - 1'b1;
        end
        S_CHECK: begin
          if (any_success) begin
            state_nxt     = S_FOUND;
            win_idx_nxt   = prio_idx;
            win_nonce_nxt = nonce_out;
          end else if (nonce_out == nonce_end_in) begin
            state_nxt = S_EXHAUSTED;
          end else begin
            nonce_nxt = nonce_out + 1'b1;
            state_nxt = S_START;
          end
        end
        default: ;
      endcase
    end
  end

  // Heartbeat counter restarts only when a job begins from a non-busy state
  assign led_cnt_nxt = (state_nxt == S_START && !busy_out) ? '0 : led_cnt + 1'b1;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state            <= S_WAIT_LOCK;
      lock_cnt         <= '0;
      round_cnt        <= '0;
      led_cnt          <= '0;
      nonce_out        <= '0;
      winner_idx_out   <= '0;
      winner_nonce_out <= '0;
      core_reset_out   <= 1'b1;
      core_start_out   <= 1'b0;
      exhausted_out    <= 1'b0;
      status_led_out   <= 1'b0;
    end else begin
      state            <= state_nxt;
      lock_cnt         <= lock_cnt_nxt;
      round_cnt        <= round_cnt_nxt;
      led_cnt          <= led_cnt_nxt;
      nonce_out        <= nonce_nxt;
      winner_idx_out   <= win_idx_nxt;
      winner_nonce_out <= win_nonce_nxt;
      core_reset_out   <= (state_nxt == S_WAIT_LOCK) || pool_rst_pulse;
      core_start_out   <= (state_nxt == S_START);
      exhausted_out    <= (state_nxt == S_EXHAUSTED);
      status_led_out   <= (state_nxt == S_FOUND) || (busy_nxt && led_cnt_nxt[LED_DIV]);
    end
  end

endmodule

// File: tb/tb_shapool_job_ctrl.sv
// Scoreboard bench for shapool_job_ctrl: job-level reference model feeds an
// event queue, a negedge monitor checks round starts and job outcomes.
module tb_shapool_job_ctrl;
  localparam int RC = 66;
  localparam int EV_START = 0, EV_FOUND = 1, EV_EXH = 2;

  typedef struct {
    int          kind;
    logic [31:0] nonce;
    logic        idx;
    int          gap;
  } exp_t;

  logic        clk_in, reset_in, pll_locked_in, job_valid_in, job_abort_in;
  logic [31:0] nonce_end_in;
  logic [1:0]  core_success_in;
  logic        core_reset_out, core_start_out, ready_out, exhausted_out, busy_out, status_led_out;
  logic [31:0] nonce_out, winner_nonce_out;
  logic        winner_idx_out;

  // Narrow instance: all-ones end nonce is reachable without forcing state
  logic [2:0]  s_end, s_nonce, s_win_nonce;
  logic [1:0]  s_succ;
  logic        s_rst, s_start, s_win_idx, s_ready, s_exh, s_busy, s_led;

  shapool_job_ctrl #(.ROUND_CYCLES(RC)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .pll_locked_in(pll_locked_in),
    .job_valid_in(job_valid_in), .job_abort_in(job_abort_in),
    .nonce_end_in(nonce_end_in), .core_success_in(core_success_in),
    .core_reset_out(core_reset_out), .core_start_out(core_start_out),
    .nonce_out(nonce_out), .winner_idx_out(winner_idx_out),
    .winner_nonce_out(winner_nonce_out), .ready_out(ready_out),
    .exhausted_out(exhausted_out), .busy_out(busy_out),
    .status_led_out(status_led_out));

  shapool_job_ctrl #(.NONCE_WIDTH(3), .ROUND_CYCLES(2), .STARTUP_CYCLES(1), .LED_DIV(4)) dut_s (
    .clk_in(clk_in), .reset_in(reset_in), .pll_locked_in(pll_locked_in),
    .job_valid_in(job_valid_in), .job_abort_in(job_abort_in),
    .nonce_end_in(s_end), .core_success_in(s_succ),
    .core_reset_out(s_rst), .core_start_out(s_start),
    .nonce_out(s_nonce), .winner_idx_out(s_win_idx),
    .winner_nonce_out(s_win_nonce), .ready_out(s_ready),
    .exhausted_out(s_exh), .busy_out(s_busy),
    .status_led_out(s_led));

  int   tests = 0, fails = 0;
  int   cyc = 0, last_start = 0;
  exp_t sb_q[$];
  logic [1:0] st [16];

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired (required: bench completes)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] nonce, input logic idx, input int gap);
    exp_t e;
    e.kind = kind; e.nonce = nonce; e.idx = idx; e.gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic handle_evt(input int kind);
    exp_t e;
    if (sb_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL unexpected_event: got kind %0d nonce %0h, required no event", kind, nonce_out);
      return;
    end
    e = sb_q.pop_front();
    check("evt_kind", 32'(kind), 32'(e.kind));
    if (e.gap != 0) check("evt_gap", 32'(cyc - last_start), 32'(e.gap));
    case (kind)
      EV_START: begin
        check("start_nonce", nonce_out, e.nonce);
        if (e.gap == 0) begin
          check("winner_idx_clr", 32'(winner_idx_out), 32'd0);
          check("winner_nonce_clr", winner_nonce_out, 32'd0);
        end
        last_start = cyc;
      end
      EV_FOUND: begin
        check("win_idx", 32'(winner_idx_out), 32'(e.idx));
        check("win_nonce", winner_nonce_out, e.nonce);
        check("found_led", 32'(status_led_out), 32'd1);
      end
      default: begin
        check("exh_nonce", nonce_out, e.nonce);
        check("exh_led", 32'(status_led_out), 32'd0);
      end
    endcase
  endtask

  // Monitor: edge-detect the three observable events at every negedge
  initial begin
    logic p_start, p_ready, p_exh;
    p_start = 1'b0; p_ready = 1'b0; p_exh = 1'b0;
    forever begin
      @(negedge clk_in);
      cyc++;
      if (core_start_out && !p_start) handle_evt(EV_START);
      if (ready_out && !p_ready)      handle_evt(EV_FOUND);
      if (exhausted_out && !p_exh)    handle_evt(EV_EXH);
      p_start = core_start_out; p_ready = ready_out; p_exh = exhausted_out;
    end
  end

  task automatic pulse_valid();
    @(negedge clk_in) job_valid_in = 1'b1;
    @(negedge clk_in) job_valid_in = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk_in) job_abort_in = 1'b1;
    @(negedge clk_in) job_abort_in = 1'b0;
  endtask

  task automatic pulse_both();
    @(negedge clk_in) begin job_abort_in = 1'b1; job_valid_in = 1'b1; end
    @(negedge clk_in) begin job_abort_in = 1'b0; job_valid_in = 1'b0; end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (core_start_out) begin ok = 1'b1; break; end
      @(negedge clk_in);
    end
    if (!ok) begin tests++; fails++; $display("FAIL start_timeout: no core_start_out, required one"); end
  endtask

  task automatic clear_st();
    for (int i = 0; i < 16; i++) st[i] = 2'b00;
  endtask

  // Reference model: rounds 0..e in order, first successful round ends the job
  task automatic run_job(input int e);
    int rounds;
    bit found, ok;
    found = 1'b0; rounds = 0;
    for (int n = 0; n <= e; n++) begin
      push(EV_START, 32'(n), 1'b0, (n == 0) ? 0 : RC + 1);
      rounds++;
      if (st[n] != 2'b00) begin
        push(EV_FOUND, 32'(n), st[n][0] ? 1'b0 : 1'b1, RC + 1);
        found = 1'b1;
        break;
      end
    end
    if (!found) push(EV_EXH, 32'(e), 1'b0, RC + 1);
    nonce_end_in = 32'(e);
    pulse_valid();
    for (int k = 0; k < rounds; k++) begin
      wait_start(ok);
      core_success_in = st[k];
      @(negedge clk_in);
    end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ready_out || exhausted_out) begin ok = 1'b1; break; end
      @(negedge clk_in);
    end
    check("job_done", 32'(ok), 32'd1);
    @(negedge clk_in);
  endtask

  initial begin
    int  fall;
    bit  ok, saw, wrapped;
    logic [2:0] prev_s;
    reset_in = 1'b1; pll_locked_in = 1'b1; job_valid_in = 1'b0; job_abort_in = 1'b0;
    nonce_end_in = '0; core_success_in = '0; s_end = 3'b111; s_succ = 2'b00;
    clear_st();

    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_core_reset", 32'(core_reset_out), 32'd1);
    check("rst_outs", {25'd0, core_start_out, ready_out, exhausted_out, busy_out, status_led_out, winner_idx_out, 1'b0}, 32'd0);
    check("rst_nonce", nonce_out, 32'd0);
    check("rst_win_nonce", winner_nonce_out, 32'd0);

    // Lock counting from release
    reset_in = 1'b0;
    fall = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_in);
      if (!core_reset_out) begin fall = k; break; end
    end
    check("lock_release_cycles", 32'(fall), 32'd16);

    // Glitch at cycle 10 restarts the count
    reset_in = 1'b1;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
    repeat (10) @(negedge clk_in);
    pll_locked_in = 1'b0;
    @(negedge clk_in);
    pll_locked_in = 1'b1;
    fall = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_in);
      if (!core_reset_out) begin fall = k; break; end
    end
    check("lock_glitch_cycles", 32'(fall), 32'd16);

    // Exhaustion with end = 2, nonce holds
    clear_st();
    run_job(2);
    repeat (30) @(negedge clk_in);
    check("exh_hold", 32'(exhausted_out), 32'd1);
    check("exh_nonce_hold", nonce_out, 32'd2);

    // Both cores succeed on round 1; bit 0 wins
    clear_st(); st[1] = 2'b11;
    run_job(3);
    repeat (30) @(negedge clk_in);
    check("found_ready_hold", 32'(ready_out), 32'd1);
    check("found_led_hold", 32'(status_led_out), 32'd1);
    check("found_idx_hold", 32'(winner_idx_out), 32'd0);
    check("found_nonce_hold", winner_nonce_out, 32'd1);
    pulse_abort();
    check("abort_found_ready", 32'(ready_out), 32'd0);
    check("abort_found_led", 32'(status_led_out), 32'd0);
    check("abort_found_norst", 32'(core_reset_out), 32'd0);

    // Abort during RUN
    clear_st(); core_success_in = 2'b00; nonce_end_in = 32'd5;
    push(EV_START, 32'd0, 1'b0, 0);
    pulse_valid();
    repeat (10) @(negedge clk_in);
    pulse_abort();
    check("abort_run_busy", 32'(busy_out), 32'd0);
    check("abort_run_rst", 32'(core_reset_out), 32'd1);
    @(negedge clk_in);
    check("abort_run_rst_end", 32'(core_reset_out), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (core_start_out) saw = 1'b1;
    end
    check("abort_no_start", 32'(saw), 32'd0);

    // Abort and valid together: abort wins
    push(EV_START, 32'd0, 1'b0, 0);
    pulse_valid();
    repeat (10) @(negedge clk_in);
    pulse_both();
    check("both_busy", 32'(busy_out), 32'd0);
    check("both_no_start", 32'(core_start_out), 32'd0);
    check("both_rst", 32'(core_reset_out), 32'd1);
    repeat (5) @(negedge clk_in);

    // Supersede mid-RUN at nonce 5
    clear_st(); nonce_end_in = 32'd9;
    for (int n = 0; n <= 5; n++) push(EV_START, 32'(n), 1'b0, (n == 0) ? 0 : RC + 1);
    push(EV_START, 32'd0, 1'b0, 0);
    pulse_valid();
    for (int k = 0; k <= 5; k++) begin
      wait_start(ok);
      @(negedge clk_in);
    end
    repeat (20) @(negedge clk_in);
    check("pre_super_nonce", nonce_out, 32'd5);
    pulse_valid();
    check("super_start", 32'(core_start_out), 32'd1);
    check("super_nonce", nonce_out, 32'd0);
    check("super_norst", 32'(core_reset_out), 32'd0);
    pulse_abort();

    // All-ones end nonce on the narrow instance: no wrap
    clear_st(); core_success_in = 2'b00;
    push(EV_START, 32'd0, 1'b0, 0);
    push(EV_EXH, 32'd0, 1'b0, RC + 1);
    nonce_end_in = 32'd0;
    pulse_valid();
    wrapped = 1'b0; prev_s = s_nonce;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_in);
      if (s_nonce < prev_s) wrapped = 1'b1;
      prev_s = s_nonce;
    end
    check("ones_no_wrap", 32'(wrapped), 32'd0);
    check("ones_exh", 32'(s_exh), 32'd1);
    check("ones_nonce", 32'(s_nonce), 32'd7);

    // Lock loss in FOUND
    clear_st(); st[0] = 2'b10;
    run_job(0);
    pll_locked_in = 1'b0;
    @(negedge clk_in);
    check("lockloss_ready", 32'(ready_out), 32'd0);
    check("lockloss_rst", 32'(core_reset_out), 32'd1);
    pll_locked_in = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (!core_reset_out) begin ok = 1'b1; break; end
    end
    check("relock", 32'(ok), 32'd1);

    // Randomized jobs
    for (int j = 0; j < 15; j++) begin
      int e;
      clear_st();
      e = $urandom_range(0, 3);
      for (int n = 0; n <= e; n++)
        if ($urandom_range(0, 3) == 0) st[n] = 2'($urandom_range(1, 3));
      run_job(e);
      if ($urandom_range(0, 1) == 1) begin
        pulse_abort();
        check("rand_abort_norst", 32'(core_reset_out), 32'd0);
        check("rand_abort_idle", 32'({ready_out, exhausted_out, busy_out}), 32'd0);
      end
      repeat ($urandom_range(1, 8)) @(negedge clk_in);
    end

    repeat (5) @(negedge clk_in);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
